// File: rtl/cpu_run_ctrl.sv
// Run/programming controller for the 8-bit CPU: input synchronizers, step-button
// debounce, auto-rate clock-enable divider and the RUN/PROG/WRITE/EXIT sequencer.
module cpu_run_ctrl #(
  parameter int AUTO_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_auto_en,
  input  logic       clk_step,
  input  logic       programming_en,
  input  logic [7:0] ProgrammingAddress,
  input  logic [7:0] ProgrammingData,
  output logic       cpu_ce,
  output logic       cpu_hold,
  output logic       cpu_reset,
  output logic       mem_sel,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_we,
  output logic [1:0] ctrl_state
);

  localparam int IN_W  = 19;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PROG  = 2'd1,
    WRITE = 2'd2,
    EXIT  = 2'd3
  } state_t;

  state_t state;

  // Switches are treated as quasi-static, so the address/data bus shares the
  // plain flop chain with the control bits.
  logic [IN_W-1:0] sync_q [SYNC_STAGES];
  logic            auto_s, step_s, prog_s;
  logic [7:0]      addr_s, data_s;

  // NOTE: every stage of the synchronizer array is reset explicitly; a register
  // array left unreset would power up with random levels on the CPU side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take its neighbour's
      // old value, which is what forms a shift chain.
      sync_q[0] <= {clk_auto_en, clk_step, programming_en, ProgrammingAddress, ProgrammingData};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {auto_s, step_s, prog_s, addr_s, data_s} = sync_q[SYNC_STAGES-1];

  logic             deb, deb_d;
  logic [CNT_W-1:0] cnt;
  logic             step_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      deb_d <= deb;
      if (step_s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb <= step_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign step_edge = deb & ~deb_d;

  logic [DIV_W-1:0] divcnt;
  logic             tick;

  assign tick = (divcnt == DIV_W'(AUTO_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divcnt <= '0;
    end else if (state != RUN || !auto_s) begin
      divcnt <= '0;
    end else if (tick) begin
      divcnt <= '0;
    end else begin
      divcnt <= divcnt + DIV_W'(1);
    end
  end

  // Strobes default low each cycle so every pulse is exactly one cycle wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      cpu_ce    <= 1'b0;
      cpu_hold  <= 1'b0;
      cpu_reset <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_data  <= 8'h00;
    end else begin
      cpu_ce    <= 1'b0;
      cpu_reset <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        RUN: begin
          if (prog_s) begin
            state    <= PROG;
            cpu_hold <= 1'b1;
          end else begin
            cpu_ce <= auto_s ? tick : step_edge;
          end
        end
        PROG: begin
          if (step_edge) begin
            state    <= WRITE;
            mem_we   <= 1'b1;
            mem_addr <= addr_s;
            mem_data <= data_s;
          end else if (!prog_s) begin
            state     <= EXIT;
            cpu_reset <= 1'b1;
          end
        end
        WRITE: begin
          if (prog_s) begin
            state <= PROG;
          end else begin
            state     <= EXIT;
            cpu_reset <= 1'b1;
          end
        end
        EXIT: begin
          state    <= RUN;
          cpu_hold <= 1'b0;
        end
        default: begin
          state    <= RUN;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  assign mem_sel    = cpu_hold;
  assign ctrl_state = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed test-plan scenarios plus a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_cpu_run_ctrl;

  localparam int AD = 5;
  localparam int DC = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_auto_en = 1'b0;
  logic       clk_step = 1'b0;
  logic       programming_en = 1'b0;
  logic [7:0] ProgrammingAddress = 8'h00;
  logic [7:0] ProgrammingData = 8'h00;
  logic       cpu_ce, cpu_hold, cpu_reset, mem_sel, mem_we;
  logic [7:0] mem_addr, mem_data;
  logic [1:0] ctrl_state;

  int checks = 0;
  int errors = 0;

  cpu_run_ctrl #(.AUTO_DIV(AD), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .clk_auto_en(clk_auto_en), .clk_step(clk_step),
    .programming_en(programming_en), .ProgrammingAddress(ProgrammingAddress),
    .ProgrammingData(ProgrammingData), .cpu_ce(cpu_ce), .cpu_hold(cpu_hold),
    .cpu_reset(cpu_reset), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input history queue, run-length debounce, modulo divider.
  logic [18:0] hist[$];
  int          m_run, m_div, m_state;
  bit          m_deb, m_deb_d, m_ce, m_we, m_rst;
  logic [7:0]  m_addr, m_data;

  task automatic model_reset();
    hist = {};
    repeat (SS) hist.push_back('0);
    m_run = 0; m_div = 0; m_state = 0;
    m_deb = 0; m_deb_d = 0; m_ce = 0; m_we = 0; m_rst = 0;
    m_addr = 8'h00; m_data = 8'h00;
  endtask

  task automatic model_step();
    logic       a_s, st_s, p_s;
    logic [7:0] a, d;
    bit         edge_seen, tick_seen;
    {a_s, st_s, p_s, a, d} = hist[0];
    edge_seen = m_deb && !m_deb_d;
    tick_seen = (m_div == AD - 1);
    void'(hist.pop_front());
    hist.push_back({clk_auto_en, clk_step, programming_en, ProgrammingAddress, ProgrammingData});
    m_deb_d = m_deb;
    if (st_s != m_deb) begin
      m_run++;
      if (m_run == DC) begin m_deb = st_s; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_div = (m_state == 0 && a_s) ? (m_div + 1) % AD : 0;
    m_ce = 0; m_we = 0; m_rst = 0;
    case (m_state)
      0: if (p_s) m_state = 1; else m_ce = a_s ? tick_seen : edge_seen;
      1: if (edge_seen) begin m_state = 2; m_we = 1; m_addr = a; m_data = d; end
         else if (!p_s) begin m_state = 3; m_rst = 1; end
      2: if (p_s) m_state = 1; else begin m_state = 3; m_rst = 1; end
      default: m_state = 0;
    endcase
  endtask

  always @(posedge clk) if (!reset) model_step();

  task automatic tick_cycle();
    @(negedge clk);
    check("cpu_ce", cpu_ce, m_ce);
    check("cpu_hold", cpu_hold, m_state != 0);
    check("mem_sel", mem_sel, m_state != 0);
    check("cpu_reset", cpu_reset, m_rst);
    check("mem_we", mem_we, m_we);
    check("mem_addr", mem_addr, m_addr);
    check("mem_data", mem_data, m_data);
    check("ctrl_state", ctrl_state, m_state);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  int  n_ce, n_we, n_rst, last;
  bit  found;

  initial begin
    model_reset();
    run(3);
    reset = 1'b0;

    // Auto clock: pulses exactly AD cycles apart; step presses are ignored.
    clk_auto_en = 1'b1;
    n_ce = 0; last = -1;
    for (int i = 0; i < 40; i++) begin
      tick_cycle();
      clk_step = (i >= 10 && i < 25);
      if (cpu_ce) begin
        if (last >= 0) check("auto_gap", i - last, AD);
        last = i; n_ce++;
      end
    end
    check("auto_pulses_ge6", n_ce >= 6, 1);
    clk_auto_en = 1'b0;
    clk_step = 1'b0;
    run(12);

    // Step: short bounce gives nothing, a long press gives one enable.
    n_ce = 0;
    for (int i = 0; i < 42; i++) begin
      clk_step = (i < 2) || (i >= 10 && i < 20);
      tick_cycle();
      if (cpu_ce) n_ce++;
    end
    check("step_pulses", n_ce, 1);

    // Programming write of 0x3A <- 0xC5.
    programming_en = 1'b1; ProgrammingAddress = 8'h3A; ProgrammingData = 8'hC5;
    run(6);
    check("prog_state", ctrl_state, 1);
    n_we = 0; n_ce = 0;
    for (int i = 0; i < 22; i++) begin
      clk_step = (i < 10);
      tick_cycle();
      if (cpu_ce) n_ce++;
      if (mem_we) begin
        n_we++;
        check("prog_addr", mem_addr, 8'h3A);
        check("prog_data", mem_data, 8'hC5);
      end
    end
    check("prog_we_count", n_we, 1);
    check("prog_no_ce", n_ce, 0);

    // Programming dropped so that it is seen together with the step edge.
    ProgrammingAddress = 8'h55; ProgrammingData = 8'hAA;
    clk_step = 1'b1;
    n_we = 0; n_rst = 0;
    for (int i = 1; i <= 25; i++) begin
      tick_cycle();
      if (mem_we) n_we++;
      if (cpu_reset) n_rst++;
      if (i == 4) programming_en = 1'b0;
      if (i == 10) clk_step = 1'b0;
    end
    check("exit_we_count", n_we, 1);
    check("exit_rst_count", n_rst, 1);
    check("exit_state", ctrl_state, 0);
    check("exit_hold", cpu_hold, 0);
    check("exit_sel", mem_sel, 0);
    check("exit_addr", mem_addr, 8'h55);

    // Reset asserted in the middle of a WRITE cycle.
    programming_en = 1'b1; ProgrammingAddress = 8'h81; ProgrammingData = 8'h7E;
    run(6);
    clk_step = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick_cycle();
      found = mem_we;
    end
    check("write_seen", found, 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_state", ctrl_state, 0);
    check("rst_mem_addr", mem_addr, 8'h00);
    clk_step = 1'b0; programming_en = 1'b0;
    run(3);
    reset = 1'b0;
    run(10);

    // Programming request landing on the auto tick suppresses that enable.
    clk_auto_en = 1'b1;
    run(12);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick_cycle();
      found = (m_state == 0 && m_div == AD - 3);
    end
    check("tick_align", found, 1);
    programming_en = 1'b1;
    n_ce = 0;
    for (int i = 0; i < 8; i++) begin
      tick_cycle();
      if (cpu_ce) n_ce++;
    end
    check("tick_prog_no_ce", n_ce, 0);
    check("tick_prog_state", ctrl_state, 1);
    programming_en = 1'b0; clk_auto_en = 1'b0;
    run(10);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      tick_cycle();
      if ($urandom_range(5) == 0) clk_step = ~clk_step;
      if ($urandom_range(79) == 0) clk_auto_en = ~clk_auto_en;
      if ($urandom_range(49) == 0) programming_en = ~programming_en;
      if ($urandom_range(3) == 0) ProgrammingAddress = 8'($urandom);
      if ($urandom_range(3) == 0) ProgrammingData = 8'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
